// File: rtl/bus_cmd_if.sv
// Request / issue / response / completion bundle for bus_cmd_engine.
// The slave modport is the engine's view; master is the surrounding system.
interface bus_cmd_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [ID_W-1:0]   req_id;

  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_cmd;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic [ID_W-1:0]   issue_id;

  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              cpl_valid;
  logic [ID_W-1:0]   cpl_id;
  logic [DATA_W-1:0] cpl_data;
  logic              cpl_err;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, req_id,
    output req_ready,
    output issue_valid, issue_cmd, issue_addr, issue_data, issue_id,
    input  issue_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output cpl_valid, cpl_id, cpl_data, cpl_err
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_data, req_id,
    input  req_ready,
    input  issue_valid, issue_cmd, issue_addr, issue_data, issue_id,
    output issue_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  cpl_valid, cpl_id, cpl_data, cpl_err
  );
endinterface

// File: rtl/bus_cmd_engine.sv
// Command engine: accepts tagged requests, issues them downstream, tracks
// in-flight IDs, turns responses into completions and latches the first error.
module bus_cmd_engine #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255,
  localparam int OUT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  bus_cmd_if.slave         bus,
  input  logic             err_clear,
  output logic [1:0]       state,
  output logic [OUT_W-1:0] outstanding,
  output logic [1:0]       err_cause
);
  localparam int NIDS  = 2 ** ID_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        cause_reg, cause_next;
  logic [NIDS-1:0]   inflight_reg, inflight_next;
  logic [OUT_W-1:0]  out_reg, out_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;

  logic              issue_valid_reg;
  logic [1:0]        issue_cmd_reg;
  logic [ADDR_W-1:0] issue_addr_reg;
  logic [DATA_W-1:0] issue_data_reg;
  logic [ID_W-1:0]   issue_id_reg;

  logic              cpl_valid_reg;
  logic [ID_W-1:0]   cpl_id_reg;
  logic [DATA_W-1:0] cpl_data_reg;
  logic              cpl_err_reg;

  logic accept, acc_ok, acc_bad, rsp_hit, rsp_miss, issue_fire, tmo_expire;

  assign bus.req_ready = !rst && (state_reg != ST_ERROR)
                       && (!issue_valid_reg || bus.issue_ready)
                       && (out_reg < OUT_W'(MAX_OUT))
                       && !inflight_reg[bus.req_id];

  assign accept     = bus.req_valid && bus.req_ready;
  assign acc_ok     = accept && (bus.req_cmd != 2'd3);
  assign acc_bad    = accept && (bus.req_cmd == 2'd3);
  assign rsp_hit    = bus.rsp_valid && inflight_reg[bus.rsp_id];
  assign rsp_miss   = bus.rsp_valid && !inflight_reg[bus.rsp_id];
  assign issue_fire = issue_valid_reg && bus.issue_ready;

  // A request and a response never name the same ID in one cycle, so set/clear cannot collide.
  generate
    for (genvar gi = 0; gi < NIDS; gi++) begin : g_inflight
      assign inflight_next[gi] =
          (inflight_reg[gi] && !(rsp_hit && (bus.rsp_id == ID_W'(gi))))
        || (acc_ok && (bus.req_id == ID_W'(gi)));
    end
  endgenerate

  always_comb begin
    out_next = out_reg;
    case ({acc_ok, rsp_hit})
      2'b10:   out_next = out_reg + OUT_W'(1);
      2'b01:   out_next = out_reg - OUT_W'(1);
      default: out_next = out_reg;
    endcase
  end

  // Silence counter saturates at TIMEOUT so the expiry stays asserted until serviced.
  always_comb begin
    tmo_next = tmo_reg;
    if (bus.rsp_valid || (out_reg == '0))
      tmo_next = '0;
    else if (tmo_reg != TMO_W'(TIMEOUT))
      tmo_next = tmo_reg + TMO_W'(1);
  end
  assign tmo_expire = (tmo_next == TMO_W'(TIMEOUT));

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    if (state_reg == ST_ERROR) begin
      if (err_clear && (out_reg == '0)) begin
        state_next = ST_IDLE;
        cause_next = 2'd0;
      end
    end else if (rsp_miss) begin
      state_next = ST_ERROR;
      cause_next = 2'd1;
    end else if (acc_bad) begin
      state_next = ST_ERROR;
      cause_next = 2'd2;
    end else if (tmo_expire) begin
      state_next = ST_ERROR;
      cause_next = 2'd3;
    end else if (out_next == '0) begin
      state_next = ST_IDLE;
    end else if (out_next == OUT_W'(MAX_OUT)) begin
      state_next = ST_WAIT;
    end else begin
      state_next = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cause_reg    <= 2'd0;
      inflight_reg <= '0;
      out_reg      <= '0;
      tmo_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cause_reg    <= cause_next;
      inflight_reg <= inflight_next;
      out_reg      <= out_next;
      tmo_reg      <= tmo_next;
    end
  end

  // Issue register: a new accept may reload it in the same cycle the old one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_reg <= 1'b0;
      issue_cmd_reg   <= '0;
      issue_addr_reg  <= '0;
      issue_data_reg  <= '0;
      issue_id_reg    <= '0;
    end else if (acc_ok) begin
      issue_valid_reg <= 1'b1;
      issue_cmd_reg   <= bus.req_cmd;
      issue_addr_reg  <= bus.req_addr;
      issue_data_reg  <= bus.req_data;
      issue_id_reg    <= bus.req_id;
    end else if (issue_fire) begin
      issue_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_valid_reg <= 1'b0;
      cpl_id_reg    <= '0;
      cpl_data_reg  <= '0;
      cpl_err_reg   <= 1'b0;
    end else begin
      cpl_valid_reg <= rsp_hit;
      if (rsp_hit) begin
        cpl_id_reg   <= bus.rsp_id;
        cpl_data_reg <= bus.rsp_data;
        cpl_err_reg  <= bus.rsp_err;
      end
    end
  end

  assign bus.issue_valid = issue_valid_reg;
  assign bus.issue_cmd   = issue_cmd_reg;
  assign bus.issue_addr  = issue_addr_reg;
  assign bus.issue_data  = issue_data_reg;
  assign bus.issue_id    = issue_id_reg;
  assign bus.cpl_valid   = cpl_valid_reg;
  assign bus.cpl_id      = cpl_id_reg;
  assign bus.cpl_data    = cpl_data_reg;
  assign bus.cpl_err     = cpl_err_reg;

  assign state       = state_reg;
  assign outstanding = out_reg;
  assign err_cause   = cause_reg;
endmodule

// File: tb/tb_bus_cmd_engine.sv
// Directed bench for bus_cmd_engine: stimulus queues expectations, a negedge
// monitor compares issues, completions and status against them.
module tb_bus_cmd_engine;
  localparam int K_STATE = 0, K_OUT = 1, K_CAUSE = 2, K_RDY = 3, K_IV = 4,
                 K_CV = 5, K_IADDR = 6, K_IID = 7, K_IDATA = 8;

  logic       clk;
  logic       rst;
  logic       err_clear;
  logic [1:0] state;
  logic [2:0] outstanding;
  logic [1:0] err_cause;

  bus_cmd_if #(.ADDR_W(8), .DATA_W(32), .ID_W(4)) bif ();

  bus_cmd_engine #(
    .ADDR_W(8), .DATA_W(32), .ID_W(4), .MAX_OUT(4), .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bif),
    .err_clear  (err_clear),
    .state      (state),
    .outstanding(outstanding),
    .err_cause  (err_cause)
  );

  typedef struct { int kind; logic [31:0] exp; string name; } st_t;
  typedef struct { logic [1:0] cmd; logic [7:0] addr; logic [31:0] data; logic [3:0] id; } iss_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic err; } cpl_t;

  st_t  st_q[$];
  iss_t iss_q[$];
  cpl_t cpl_q[$];
  st_t  cur_st;
  iss_t cur_iss;
  cpl_t cur_cpl;

  int n_vec = 0;
  int n_err = 0;
  bit end_req = 0;
  bit end_done = 0;
  int rsp_ids[4] = '{0, 2, 3, 4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_STATE: return 32'(state);
      K_OUT:   return 32'(outstanding);
      K_CAUSE: return 32'(err_cause);
      K_RDY:   return 32'(bif.req_ready);
      K_IV:    return 32'(bif.issue_valid);
      K_CV:    return 32'(bif.cpl_valid);
      K_IADDR: return 32'(bif.issue_addr);
      K_IID:   return 32'(bif.issue_id);
      K_IDATA: return bif.issue_data;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    while (st_q.size() > 0) begin
      cur_st = st_q.pop_front();
      chk(cur_st.name, actual(cur_st.kind), cur_st.exp);
    end
    if (!rst && bif.issue_valid && bif.issue_ready) begin
      if (iss_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL issue_unexpected: got id %0d addr %h, required no issue", bif.issue_id, bif.issue_addr);
      end else begin
        cur_iss = iss_q.pop_front();
        $display("issue  cmd=%0d id=%0d addr=%h data=%h", bif.issue_cmd, bif.issue_id, bif.issue_addr, bif.issue_data);
        chk("issue_cmd",  32'(bif.issue_cmd),  32'(cur_iss.cmd));
        chk("issue_addr", 32'(bif.issue_addr), 32'(cur_iss.addr));
        chk("issue_data", bif.issue_data,      cur_iss.data);
        chk("issue_id",   32'(bif.issue_id),   32'(cur_iss.id));
      end
    end
    if (!rst && bif.cpl_valid) begin
      if (cpl_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL cpl_unexpected: got id %0d, required no completion", bif.cpl_id);
      end else begin
        cur_cpl = cpl_q.pop_front();
        $display("cpl    id=%0d data=%h err=%0d", bif.cpl_id, bif.cpl_data, bif.cpl_err);
        chk("cpl_id",   32'(bif.cpl_id),  32'(cur_cpl.id));
        chk("cpl_data", bif.cpl_data,     cur_cpl.data);
        chk("cpl_err",  32'(bif.cpl_err), 32'(cur_cpl.err));
      end
    end
    if (end_req && !end_done) begin
      chk("issue_q_left", 32'(iss_q.size()), 32'd0);
      chk("cpl_q_left",   32'(cpl_q.size()), 32'd0);
      end_done = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int kind, input logic [31:0] exp, input string name);
    st_q.push_back('{kind, exp, name});
  endtask

  task automatic drv_req(input logic [1:0] cmd, input logic [3:0] id, input logic [7:0] addr, input logic [31:0] data);
    bif.req_valid = 1'b1;
    bif.req_cmd   = cmd;
    bif.req_id    = id;
    bif.req_addr  = addr;
    bif.req_data  = data;
  endtask

  task automatic push_iss(input logic [1:0] cmd, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] id);
    iss_q.push_back('{cmd, addr, data, id});
  endtask

  task automatic drv_rsp(input logic [3:0] id, input logic [31:0] data, input logic err);
    bif.rsp_valid = 1'b1;
    bif.rsp_id    = id;
    bif.rsp_data  = data;
    bif.rsp_err   = err;
  endtask

  task automatic push_cpl(input logic [3:0] id, input logic [31:0] data, input logic err);
    cpl_q.push_back('{id, data, err});
  endtask

  initial begin
    rst = 1'b1; err_clear = 1'b0;
    bif.req_valid = 0; bif.req_cmd = 0; bif.req_addr = 0; bif.req_data = 0; bif.req_id = 0;
    bif.issue_ready = 1'b1;
    bif.rsp_valid = 0; bif.rsp_id = 0; bif.rsp_data = 0; bif.rsp_err = 0;

    // Reset values
    step();
    ex(K_RDY, 0, "rdy_in_rst");
    step();
    rst = 1'b0;
    ex(K_STATE, 0, "rst_state"); ex(K_OUT, 0, "rst_out"); ex(K_CAUSE, 0, "rst_cause");
    ex(K_IV, 0, "rst_iv"); ex(K_CV, 0, "rst_cv"); ex(K_RDY, 1, "rdy_after_rst");

    // Single READ round trip
    drv_req(2'd0, 4'd3, 8'h10, 32'h0);
    push_iss(2'd0, 8'h10, 32'h0, 4'd3);
    step();
    bif.req_valid = 0;
    ex(K_IV, 1, "rd_iv"); ex(K_OUT, 1, "rd_out1"); ex(K_STATE, 1, "rd_active");
    step();
    ex(K_IV, 0, "rd_iv_drop");
    drv_rsp(4'd3, 32'hDEADBEEF, 1'b0);
    push_cpl(4'd3, 32'hDEADBEEF, 1'b0);
    step();
    bif.rsp_valid = 0;
    ex(K_OUT, 0, "rd_out0"); ex(K_STATE, 0, "rd_idle"); ex(K_CV, 1, "rd_cv");
    step();
    ex(K_CV, 0, "rd_cv_drop");

    // Fill to MAX_OUT, fifth request stalls until a response
    for (int i = 0; i < 4; i++) begin
      drv_req(2'd1, 4'(i), 8'h20 + 8'(i), 32'h100 + 32'(i));
      push_iss(2'd1, 8'h20 + 8'(i), 32'h100 + 32'(i), 4'(i));
      step();
    end
    drv_req(2'd0, 4'd4, 8'h24, 32'h0);
    ex(K_STATE, 2, "full_wait"); ex(K_OUT, 4, "full_out4"); ex(K_RDY, 0, "full_rdy");
    step();
    ex(K_RDY, 0, "full_rdy_stall");
    drv_rsp(4'd1, 32'h1111, 1'b1);
    push_cpl(4'd1, 32'h1111, 1'b1);
    step();
    bif.rsp_valid = 0;
    ex(K_OUT, 3, "full_out3"); ex(K_STATE, 1, "full_active"); ex(K_RDY, 1, "full_release");
    push_iss(2'd0, 8'h24, 32'h0, 4'd4);
    step();
    bif.req_valid = 0;
    ex(K_OUT, 4, "refill_out4"); ex(K_STATE, 2, "refill_wait");
    for (int i = 0; i < 4; i++) begin
      drv_rsp(4'(rsp_ids[i]), 32'h200 + 32'(rsp_ids[i]), 1'b0);
      push_cpl(4'(rsp_ids[i]), 32'h200 + 32'(rsp_ids[i]), 1'b0);
      step();
    end
    bif.rsp_valid = 0;
    ex(K_OUT, 0, "drain_out0"); ex(K_STATE, 0, "drain_idle");

    // Same ID while in flight is held off
    drv_req(2'd0, 4'd2, 8'h30, 32'h0);
    push_iss(2'd0, 8'h30, 32'h0, 4'd2);
    step();
    drv_req(2'd0, 4'd2, 8'h31, 32'h0);
    ex(K_RDY, 0, "dup_rdy0");
    step();
    ex(K_RDY, 0, "dup_rdy1");
    drv_rsp(4'd2, 32'h2222, 1'b0);
    push_cpl(4'd2, 32'h2222, 1'b0);
    step();
    bif.rsp_valid = 0;
    ex(K_RDY, 1, "dup_release");
    push_iss(2'd0, 8'h31, 32'h0, 4'd2);
    step();
    bif.req_valid = 0;
    drv_rsp(4'd2, 32'h3333, 1'b0);
    push_cpl(4'd2, 32'h3333, 1'b0);
    step();
    bif.rsp_valid = 0;
    ex(K_OUT, 0, "dup_out0");

    // Unexpected response
    drv_rsp(4'd7, 32'h7777, 1'b0);
    step();
    bif.rsp_valid = 0;
    ex(K_STATE, 3, "unexp_err"); ex(K_CAUSE, 1, "unexp_cause"); ex(K_RDY, 0, "unexp_rdy"); ex(K_CV, 0, "unexp_cv");
    err_clear = 1;
    step();
    err_clear = 0;
    ex(K_STATE, 0, "unexp_clr_idle"); ex(K_CAUSE, 0, "unexp_clr_cause");

    // Reserved command
    drv_req(2'd3, 4'd5, 8'h5A, 32'h0);
    ex(K_RDY, 1, "rsv_rdy");
    step();
    bif.req_valid = 0;
    ex(K_STATE, 3, "rsv_err"); ex(K_CAUSE, 2, "rsv_cause"); ex(K_OUT, 0, "rsv_out"); ex(K_IV, 0, "rsv_iv");
    err_clear = 1;
    step();
    err_clear = 0;
    ex(K_STATE, 0, "rsv_clr_idle");

    // Timeout after 8 silent cycles, late response still completes
    drv_req(2'd0, 4'd6, 8'h40, 32'h0);
    push_iss(2'd0, 8'h40, 32'h0, 4'd6);
    step();
    bif.req_valid = 0;
    for (int i = 0; i < 7; i++) step();
    ex(K_STATE, 1, "tmo_not_yet");
    step();
    ex(K_STATE, 3, "tmo_err"); ex(K_CAUSE, 3, "tmo_cause"); ex(K_OUT, 1, "tmo_out");
    err_clear = 1;
    step();
    err_clear = 0;
    ex(K_STATE, 3, "tmo_clr_ignored");
    drv_rsp(4'd9, 32'h9999, 1'b0);
    step();
    ex(K_CAUSE, 3, "tmo_first_cause");
    drv_rsp(4'd6, 32'h55, 1'b0);
    push_cpl(4'd6, 32'h55, 1'b0);
    step();
    bif.rsp_valid = 0;
    ex(K_OUT, 0, "tmo_late_out0"); ex(K_STATE, 3, "tmo_still_err");
    err_clear = 1;
    step();
    err_clear = 0;
    ex(K_STATE, 0, "tmo_clr_idle"); ex(K_CAUSE, 0, "tmo_clr_cause");

    // Issue backpressure holds payload, then back-to-back reload
    bif.issue_ready = 0;
    drv_req(2'd1, 4'd1, 8'h50, 32'hCAFEF00D);
    push_iss(2'd1, 8'h50, 32'hCAFEF00D, 4'd1);
    step();
    drv_req(2'd0, 4'd8, 8'h51, 32'h0);
    for (int i = 0; i < 3; i++) begin
      ex(K_RDY, 0, "bp_rdy"); ex(K_IV, 1, "bp_iv"); ex(K_IADDR, 32'h50, "bp_addr");
      ex(K_IDATA, 32'hCAFEF00D, "bp_data"); ex(K_IID, 1, "bp_id");
      step();
    end
    bif.issue_ready = 1;
    ex(K_RDY, 1, "bp_rdy_b2b");
    push_iss(2'd0, 8'h51, 32'h0, 4'd8);
    step();
    bif.req_valid = 0;
    ex(K_IV, 1, "b2b_iv"); ex(K_IADDR, 32'h51, "b2b_addr"); ex(K_OUT, 2, "b2b_out2");
    step();

    // Reset with two outstanding, old ID then unexpected
    rst = 1;
    step();
    ex(K_OUT, 0, "mrst_out"); ex(K_STATE, 0, "mrst_state"); ex(K_IV, 0, "mrst_iv");
    ex(K_CV, 0, "mrst_cv"); ex(K_IADDR, 0, "mrst_addr"); ex(K_IID, 0, "mrst_id");
    ex(K_IDATA, 0, "mrst_data"); ex(K_RDY, 0, "mrst_rdy"); ex(K_CAUSE, 0, "mrst_cause");
    step();
    rst = 0;
    drv_rsp(4'd1, 32'h1, 1'b0);
    step();
    bif.rsp_valid = 0;
    ex(K_STATE, 3, "old_id_err"); ex(K_CAUSE, 1, "old_id_cause"); ex(K_CV, 0, "old_id_cv");
    err_clear = 1;
    step();
    err_clear = 0;
    ex(K_STATE, 0, "old_id_clr");
    step();

    end_req = 1;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_cmd_engine.md
BUS_CMD_ENGINE -- requirements
Module: bus_cmd_engine

Interface
REQ-001 Parameter ADDR_W, default 8, request/issue address width.
REQ-002 Parameter DATA_W, default 32, request/issue/response data width.
REQ-003 Parameter ID_W, default 4, transaction ID width; 2**ID_W IDs.
REQ-004 Parameter MAX_OUT, default 4, max outstanding transactions (1..2**ID_W).
REQ-005 Parameter TIMEOUT, default 255, response-silence cycles before ERROR (>=1).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid, req_ready  in, out  1  request handshake.
REQ-010 req_cmd  in  2  0 READ, 1 WRITE, 2 ERASE, 3 reserved.
REQ-011 req_addr / req_data / req_id  in  ADDR_W / DATA_W / ID_W  request payload.
REQ-012 issue_valid, issue_ready  out, in  1  downstream issue handshake.
REQ-013 issue_cmd / issue_addr / issue_data / issue_id  out  2 / ADDR_W / DATA_W / ID_W  issued payload.
REQ-014 rsp_valid, rsp_id, rsp_data, rsp_err  in  1 / ID_W / DATA_W / 1  downstream response, no backpressure.
REQ-015 cpl_valid, cpl_id, cpl_data, cpl_err  out  1 / ID_W / DATA_W / 1  completion, no backpressure.
REQ-016 state  out  2  IDLE=0, ACTIVE=1, WAIT=2, ERROR=3.
REQ-017 outstanding  out  $clog2(MAX_OUT+1)  accepted, not yet responded count.
REQ-018 err_cause  out  2  0 none, 1 unexpected response, 2 reserved cmd, 3 timeout.
REQ-019 err_clear  in  1  software error acknowledge.

Function
REQ-020 req_ready = (state!=ERROR) && (!issue_valid || issue_ready) && (outstanding<MAX_OUT) && !inflight[req_id]; combinational on req_id.
REQ-021 Accept (req_valid&&req_ready) with cmd 0..2: load issue register next cycle, issue_valid=1, set inflight[req_id], outstanding+1.
REQ-022 Accept with cmd 3: no issue, no inflight, outstanding unchanged; enter ERROR, err_cause=2.
REQ-023 issue_* payload stable while issue_valid && !issue_ready; issue_valid drops after handshake unless new accept same cycle (back-to-back, 1 req/cycle throughput).
REQ-024 Response with inflight[rsp_id]=1: clear inflight[rsp_id], outstanding-1, cpl_valid=1 next cycle with cpl_id=rsp_id, cpl_data=rsp_data, cpl_err=rsp_err; cpl_valid otherwise 0.
REQ-025 Response with inflight[rsp_id]=0: dropped, no completion; enter ERROR, err_cause=1.
REQ-026 Accept and valid response same cycle: outstanding unchanged; same ID in both impossible (req_ready low).
REQ-027 Timeout counter: cleared on any rsp_valid or when outstanding==0, else +1 per cycle; reaching TIMEOUT enters ERROR, err_cause=3, counter holds.
REQ-028 err_cause records first cause only; later errors while in ERROR do not overwrite.
REQ-029 Non-ERROR state is registered from next-cycle values: IDLE if outstanding==0, WAIT if outstanding==MAX_OUT, else ACTIVE.
REQ-030 Error entry takes priority over IDLE/ACTIVE/WAIT update in same cycle.
REQ-031 In ERROR: req_ready=0; pending issue still drains; valid responses still complete and decrement.
REQ-032 err_clear in ERROR with outstanding==0: next state IDLE, err_cause=0; with outstanding>0 ignored; outside ERROR no effect.

Reset
REQ-033 rst high at edge: state=IDLE, outstanding=0, err_cause=0, issue_valid=0, cpl_valid=0, inflight all 0, timeout counter 0, payload outputs 0.
REQ-034 Reset mid-transaction discards all in-flight; later responses to old IDs are unexpected (REQ-025).
REQ-035 req_ready=0 while rst is high.

Verification
REQ-036 READ id=3 addr=8'h10, issue_ready=1, rsp id=3 data=32'hDEADBEEF 2 cycles later -> issue_valid 1 cycle, outstanding 1->0, cpl_id=3 cpl_data=DEADBEEF, state ACTIVE->IDLE.
REQ-037 4 requests ids 0..3, no responses -> state WAIT, req_ready=0, 5th request stalls; rsp id=1 -> outstanding=3, state ACTIVE, stall releases.
REQ-038 Request id=2 while id=2 inflight -> req_ready=0 until rsp id=2 completes.
REQ-039 rsp id=7 with none inflight -> no cpl_valid, state ERROR, err_cause=1; err_clear -> IDLE, err_cause=0.
REQ-040 TIMEOUT=8, one outstanding, no response -> ERROR err_cause=3 after 8 cycles; late rsp completes, outstanding=0, err_clear -> IDLE.
REQ-041 issue_ready=0 for 3 cycles then 1 -> issue payload stable throughout; rst asserted with 2 outstanding -> all outputs reset, IDLE.
